// File: rtl/dpwm_pkg.sv
// -----------------------------------------------------------------------------
// dpwm_pkg
//   Shared definitions for the DPWM core: FSM state encoding, default widths of
//   the phase accumulator and duty comparator, and the dead-time counter width.
// -----------------------------------------------------------------------------
package dpwm_pkg;

  // Run/idle control of the generator
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dpwm_state_e;

  localparam int DPWM_ACC_W  = 20;  // phase accumulator width
  localparam int DPWM_DUTY_W = 8;   // duty word / sawtooth width
  localparam int DPWM_DEAD_W = 8;   // dead counter, DEAD_CYC range 0..255

endpackage

// File: rtl/dpwm_tiempo_muerto.sv
// -----------------------------------------------------------------------------
// dpwm_tiempo_muerto
//   Splits the raw PWM into complementary high/low gate drives with a
//   break-before-make gap of DEAD_CYC clocks after every raw edge.
// Ports
//   CLK    in   system clock
//   reset  in   asynchronous, active-high reset
//   clr    in   force both drives low and restart (generator idling)
//   raw    in   raw PWM from the comparator
//   pwm_h  out  high-side drive (registered)
//   pwm_l  out  low-side drive (registered)
// -----------------------------------------------------------------------------
module dpwm_tiempo_muerto
  import dpwm_pkg::*;
#(
  parameter int DEAD_CYC = 4
) (
  input  logic CLK,
  input  logic reset,
  input  logic clr,
  input  logic raw,
  output logic pwm_h,
  output logic pwm_l
);

  localparam logic [DPWM_DEAD_W-1:0] C_DEAD = DPWM_DEAD_W'(DEAD_CYC);
  // With no dead time the stage degenerates to a one-register pass-through.
  localparam logic C_PASS = (DEAD_CYC == 0);

  logic [DPWM_DEAD_W-1:0] r_cnt;
  logic                   r_raw_q;
  logic                   r_armed;
  logic                   r_h;
  logic                   r_l;
  logic                   w_edge;

  // The first sample after a clear is treated as an edge so that start-up
  // also gets a full dead-time gap before either drive turns on.
  assign w_edge = ~r_armed | (raw ^ r_raw_q);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_raw_q <= 1'b0;
      r_armed <= 1'b0;
      r_h     <= 1'b0;
      r_l     <= 1'b0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_raw_q <= 1'b0;
      r_armed <= 1'b0;
      r_h     <= 1'b0;
      r_l     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_raw_q <= raw;
      if (w_edge) begin
        // Any raw transition (including one during a running count) restarts
        // the gap; a pulse no longer than DEAD_CYC never reaches its drive.
        r_cnt <= C_DEAD;
        r_h   <= C_PASS & raw;
        r_l   <= C_PASS & ~raw;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
        // Last dead cycle: the drive turns on at this edge, so the gap is
        // exactly DEAD_CYC cycles with both drives low.
        if (r_cnt == 1'b1) begin
          r_h <= raw;
          r_l <= ~raw;
        end
      end else begin
        r_h <= raw;
        r_l <= ~raw;
      end
    end
  end

  assign pwm_h = r_h;
  assign pwm_l = r_l;

  // Shoot-through guard for the half-bridge
  a_no_overlap : assert property (@(posedge CLK) disable iff (reset) !(r_h && r_l));

endmodule

// File: rtl/dpwm_generador.sv
// -----------------------------------------------------------------------------
// dpwm_generador
//   Digital PWM core. An NCO phase accumulator advances by the frequency code
//   each clock; its top DUTY_W bits form a sawtooth that is compared with the
//   duty word. The raw PWM feeds a dead-time stage driving a half-bridge.
//   f_pwm = f_CLK * frec_sh / 2^ACC_W.
// Ports
//   CLK            in   system clock
//   reset          in   asynchronous, active-high reset
//   enable         in   run request (level)
//   frecuencia     in   8-bit tuning word
//   ciclo_trabajo  in   duty word; raw high while phase < duty
//   pwm_h          out  high-side drive
//   pwm_l          out  low-side drive
//   fin_periodo    out  one-cycle pulse after each accumulator wrap
//   activo         out  generator running
// -----------------------------------------------------------------------------
module dpwm_generador
  import dpwm_pkg::*;
#(
  parameter int ACC_W    = DPWM_ACC_W,
  parameter int DUTY_W   = DPWM_DUTY_W,
  parameter int DEAD_CYC = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        frecuencia,
  input  logic [DUTY_W-1:0] ciclo_trabajo,
  output logic              pwm_h,
  output logic              pwm_l,
  output logic              fin_periodo,
  output logic              activo
);

  dpwm_state_e       r_state;
  dpwm_state_e       w_state_nxt;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [7:0]        r_frec_sh;
  logic [DUTY_W-1:0] r_duty_sh;
  logic              r_fin;
  logic [ACC_W:0]    w_sum;
  logic [DUTY_W-1:0] w_phase;
  logic              w_wrap;
  logic              w_load;
  logic              w_raw;
  logic              w_clr;

  // Extra bit catches the carry that marks the end of a period
  assign w_sum   = {1'b0, r_acc} + (ACC_W+1)'(r_frec_sh);
  assign w_phase = r_acc[ACC_W-1 -: DUTY_W];

  // ---------------------------------------------------------------------------
  // FSM next state / accumulator / shadow-load control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_wrap      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_acc_nxt = '0;
        if (enable) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_wrap    = w_sum[ACC_W];
        w_acc_nxt = w_sum[ACC_W-1:0];
        // Settings are only picked up at a period boundary
        w_load    = w_wrap;
        // A stopped request lets the period finish; with a zero tuning word
        // the accumulator is frozen and no wrap will ever arrive.
        if (!enable && (w_wrap || (r_frec_sh == '0))) begin
          w_state_nxt = IDLE;
          w_acc_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_frec_sh <= '0;
      r_duty_sh <= '0;
      r_fin     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_fin   <= w_wrap;
      if (w_load) begin
        r_frec_sh <= frecuencia;
        r_duty_sh <= ciclo_trabajo;
      end
    end
  end

  // Sawtooth comparator; duty 0 never goes high
  assign w_raw = (r_state == RUN) && (w_phase < r_duty_sh);

  // Drives drop on the same edge that enters IDLE, and stay low while idle
  assign w_clr = (w_state_nxt == IDLE);

  dpwm_tiempo_muerto #(
    .DEAD_CYC (DEAD_CYC)
  ) u_tiempo_muerto (
    .CLK   (CLK),
    .reset (reset),
    .clr   (w_clr),
    .raw   (w_raw),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );

  assign fin_periodo = r_fin;
  assign activo      = (r_state == RUN);

endmodule

// File: tb/tb_dpwm_generador.sv
module tb_dpwm_generador;

  localparam int ACC_W   = 20;
  localparam int DUTY_W  = 8;
  localparam int DEAD    = 4;
  localparam int ACC_MOD = 1 << ACC_W;

  logic       CLK;
  logic       reset;
  logic       enable;
  logic [7:0] frecuencia;
  logic [7:0] ciclo_trabajo;
  logic       pwm_h, pwm_l, fin_periodo, activo;
  logic       h32, l32, fin32, act32;

  int n_chk  = 0;
  int n_fail = 0;

  dpwm_generador u_dut (
    .CLK           (CLK),
    .reset         (reset),
    .enable        (enable),
    .frecuencia    (frecuencia),
    .ciclo_trabajo (ciclo_trabajo),
    .pwm_h         (pwm_h),
    .pwm_l         (pwm_l),
    .fin_periodo   (fin_periodo),
    .activo        (activo)
  );

  dpwm_generador #(.DEAD_CYC(32)) u_dut32 (
    .CLK           (CLK),
    .reset         (reset),
    .enable        (enable),
    .frecuencia    (frecuencia),
    .ciclo_trabajo (ciclo_trabajo),
    .pwm_h         (h32),
    .pwm_l         (l32),
    .fin_periodo   (fin32),
    .activo        (act32)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Reference model: period arithmetic plus a history window of raw samples.
  // A drive is on when the last DEAD+1 samples all agree; 2 marks an idle slot.
  // ---------------------------------------------------------------------------
  int unsigned m_acc, m_frec, m_duty;
  bit          m_run, m_fin;
  int          m_hist[$];

  task automatic model_reset();
    m_acc = 0; m_frec = 0; m_duty = 0; m_run = 0; m_fin = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit en, input int unsigned f, input int unsigned d);
    int unsigned sum;
    bit          raw, clr;
    raw = m_run && ((m_acc >> (ACC_W - DUTY_W)) < m_duty);
    clr = 0;
    m_fin = 0;
    if (!m_run) begin
      if (en) begin m_frec = f; m_duty = d; m_run = 1; end
      else clr = 1;
    end else begin
      sum   = m_acc + m_frec;
      m_fin = (sum >= ACC_MOD);
      m_acc = sum % ACC_MOD;
      if (!en && (m_fin || m_frec == 0)) begin m_run = 0; m_acc = 0; clr = 1; end
      if (m_fin) begin m_frec = f; m_duty = d; end
    end
    m_hist.push_back(clr ? 2 : int'(raw));
    if (m_hist.size() > DEAD + 1) void'(m_hist.pop_front());
  endtask

  function automatic bit model_drive(input int v);
    if (m_hist.size() < DEAD + 1) return 0;
    foreach (m_hist[i]) if (m_hist[i] != v) return 0;
    return 1;
  endfunction

  // Waits (bounded) for the next fin_periodo sample; reports elapsed cycles
  task automatic wait_fin(input int budget, output bit got, output int cycles);
    got = 0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge CLK);
      cycles++;
      if (fin_periodo) got = 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1; enable = 0; frecuencia = 0; ciclo_trabajo = 0;
    repeat (3) @(negedge CLK);
    reset = 0;
    @(negedge CLK);
    n_chk++;
    if ({pwm_h, pwm_l, fin_periodo, activo} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_state got=%b required=0000", {pwm_h, pwm_l, fin_periodo, activo});
    end
    frecuencia = 128; ciclo_trabajo = 128; enable = 1;
    repeat (200) @(negedge CLK);
    n_chk++;
    if ({activo, pwm_h, pwm_l} !== 3'b110) begin
      n_fail++; $display("FAIL pre_reset_run got act/h/l=%b required=110", {activo, pwm_h, pwm_l});
    end
    #3 reset = 1;
    #1;
    n_chk++;
    if ({pwm_h, pwm_l, fin_periodo, activo} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset got=%b required=0000", {pwm_h, pwm_l, fin_periodo, activo});
    end
    @(negedge CLK);
    enable = 0;
    reset = 0;
    @(negedge CLK);
  endtask

  // Full periods at code 128: 8192 cycles, then a duty change mid-period
  task automatic test_period_and_duty();
    bit got; int cyc, hc, lc, fc;
    frecuencia = 128; ciclo_trabajo = 128; enable = 1;
    wait_fin(8300, got, cyc);
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL first_wrap got=none within 8300 required=pulse"); end
    for (int p = 0; p < 3; p++) begin
      hc = 0; lc = 0; fc = 0;
      for (int i = 0; i < 8192; i++) begin
        hc += int'(pwm_h); lc += int'(pwm_l); fc += int'(fin_periodo);
        n_chk++;
        if (pwm_h && pwm_l) begin n_fail++; $display("FAIL overlap period=%0d i=%0d got h=l=1 required=not both", p, i); end
        if (p == 1 && i == 100) ciclo_trabajo = 64;
        @(negedge CLK);
      end
      n_chk++;
      if (hc !== (p == 2 ? 2044 : 4092)) begin
        n_fail++; $display("FAIL pwm_h_high period=%0d got=%0d required=%0d", p, hc, (p == 2 ? 2044 : 4092));
      end
      n_chk++;
      if (fc !== 1 || fin_periodo !== 1'b1) begin
        n_fail++; $display("FAIL period_len period=%0d got fins=%0d end=%b required=1,1", p, fc, fin_periodo);
      end
      if (p == 0) begin
        n_chk++;
        if (lc !== 4092) begin n_fail++; $display("FAIL pwm_l_high got=%0d required=4092", lc); end
      end
    end
  endtask

  // Drop enable 1000 cycles into a period: the period must complete
  task automatic test_disable();
    bit got; int cyc, bad;
    repeat (1000) @(negedge CLK);
    enable = 0;
    wait_fin(8300, got, cyc);
    n_chk++;
    if (!got || cyc !== 7192) begin
      n_fail++; $display("FAIL disable_finish got wrap=%b after=%0d required=1 after 7192", got, cyc);
    end
    n_chk++;
    if ({activo, pwm_h, pwm_l} !== 3'b000) begin
      n_fail++; $display("FAIL disable_idle got act/h/l=%b required=000", {activo, pwm_h, pwm_l});
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      bad += int'(fin_periodo | activo | pwm_h | pwm_l);
    end
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL disable_quiet got=%0d active samples required=0", bad); end
  endtask

  // Zero duty / zero tuning word boundaries
  task automatic test_zero_codes();
    int bad_h, bad_l, fc; bit off;
    frecuencia = 0; ciclo_trabajo = 0; enable = 1;
    bad_h = 0; bad_l = 0; fc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge CLK);
      bad_h += int'(pwm_h);
      bad_l += int'(pwm_l !== (i > DEAD));
      fc += int'(fin_periodo);
    end
    n_chk++;
    if (bad_h !== 0) begin n_fail++; $display("FAIL duty0_pwm_h got=%0d high samples required=0", bad_h); end
    n_chk++;
    if (bad_l !== 0) begin n_fail++; $display("FAIL duty0_pwm_l got=%0d wrong samples required=0", bad_l); end
    n_chk++;
    if (fc !== 0) begin n_fail++; $display("FAIL frec0_no_wrap got=%0d pulses required=0", fc); end
    enable = 0;
    off = 0;
    for (int k = 0; k < 2 && !off; k++) begin
      @(negedge CLK);
      if (!activo) off = 1;
    end
    n_chk++;
    if (!off || pwm_l !== 1'b0) begin
      n_fail++; $display("FAIL frec0_stop got act=%b l=%b required=0,0 within 2", activo, pwm_l);
    end
    // Frozen phase 0 with nonzero duty holds raw high
    ciclo_trabajo = 200; enable = 1;
    repeat (20) @(negedge CLK);
    n_chk++;
    if ({activo, pwm_h, pwm_l, fin_periodo} !== 4'b1100) begin
      n_fail++; $display("FAIL frec0_duty got act/h/l/fin=%b required=1100", {activo, pwm_h, pwm_l, fin_periodo});
    end
    enable = 0;
    repeat (3) @(negedge CLK);
  endtask

  // Narrow pulses against a long dead time
  task automatic test_dead_time();
    int h32c, l32c, hc, fc, f32c, ov; bit got; int cyc;
    frecuencia = 255; ciclo_trabajo = 1; enable = 1;
    h32c = 0; l32c = 0; hc = 0; fc = 0; f32c = 0; ov = 0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge CLK);
      h32c += int'(h32); l32c += int'(l32); hc += int'(pwm_h);
      fc += int'(fin_periodo); f32c += int'(fin32);
      ov += int'((pwm_h & pwm_l) | (h32 & l32));
    end
    n_chk++;
    if (h32c !== 0) begin n_fail++; $display("FAIL dead32_pwm_h got=%0d high samples required=0", h32c); end
    n_chk++;
    if (l32c == 0) begin n_fail++; $display("FAIL dead32_pwm_l got=0 high samples required=>0"); end
    n_chk++;
    if (hc == 0) begin n_fail++; $display("FAIL dead4_pwm_h got=0 high samples required=>0"); end
    n_chk++;
    if (ov !== 0) begin n_fail++; $display("FAIL overlap_dead got=%0d required=0", ov); end
    n_chk++;
    if (fc !== 2 || f32c !== 2) begin n_fail++; $display("FAIL dead_wraps got=%0d/%0d required=2/2", fc, f32c); end
    enable = 0;
    wait_fin(4300, got, cyc);
    @(negedge CLK);
    n_chk++;
    if (!got || {activo, act32} !== 2'b00) begin
      n_fail++; $display("FAIL dead_stop got wrap=%b act=%b%b required=1,00", got, activo, act32);
    end
  endtask

  // Random codes / duties / enable against the model, every cycle
  task automatic test_random();
    bit [3:0] exp;
    reset = 1; enable = 0;
    @(negedge CLK);
    reset = 0;
    model_reset();
    enable = 1;
    frecuencia = 8'($urandom_range(64, 255));
    ciclo_trabajo = 8'($urandom_range(0, 255));
    for (int cyc = 0; cyc < 15000; cyc++) begin
      exp = {model_drive(1), model_drive(0), m_fin, m_run};
      n_chk++;
      if ({pwm_h, pwm_l, fin_periodo, activo} !== exp) begin
        n_fail++;
        $display("FAIL random cyc=%0d got h/l/fin/act=%b required=%b", cyc, {pwm_h, pwm_l, fin_periodo, activo}, exp);
      end
      n_chk++;
      if (pwm_h && pwm_l) begin n_fail++; $display("FAIL overlap_random cyc=%0d got h=l=1 required=not both", cyc); end
      if ($urandom_range(0, 63) == 0)
        frecuencia = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(64, 255));
      if ($urandom_range(0, 63) == 0)
        case ($urandom_range(0, 3))
          0: ciclo_trabajo = 8'd0;
          1: ciclo_trabajo = 8'd255;
          default: ciclo_trabajo = 8'($urandom_range(0, 255));
        endcase
      if ($urandom_range(0, 1023) == 0) enable = ~enable;
      @(posedge CLK);
      model_step(enable, frecuencia, ciclo_trabajo);
      @(negedge CLK);
    end
  endtask

  initial begin
    reset = 1; enable = 0; frecuencia = 0; ciclo_trabajo = 0;
    test_reset();
    test_period_and_duty();
    test_disable();
    test_zero_codes();
    test_dead_time();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
